// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// instruction field positions.
package instr_sequencer_pkg;

   localparam int INSTR_W = 16;
   localparam int OP_LSB  = 12;
   localparam int OP_W    = 4;
   localparam int RD_LSB  = 9;
   localparam int RS_LSB  = 6;
   localparam int RT_LSB  = 3;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 6;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_NOP  = 4'd0;
   localparam opcode_t OP_ADD  = 4'd1;
   localparam opcode_t OP_SUB  = 4'd2;
   localparam opcode_t OP_AND  = 4'd3;
   localparam opcode_t OP_OR   = 4'd4;
   localparam opcode_t OP_XOR  = 4'd5;
   localparam opcode_t OP_SLL  = 4'd6;
   localparam opcode_t OP_SRL  = 4'd7;
   localparam opcode_t OP_ADDI = 4'd8;
   localparam opcode_t OP_MUL  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   function automatic opcode_t instr_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_LSB +: OP_W];
   endfunction

   // Opcodes above MUL are undefined and retire as illegal without a write.
   function automatic logic op_is_legal(input opcode_t op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer, its instruction source and the 8x16 register
// file read/write ports.
interface instr_sequencer_if
   import instr_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   // Handshake: an instruction transfers on the rising clock edge where
   // instr_valid and instr_ready are both high. instr_ready is high only while
   // the sequencer is idle; a source seeing ready low must hold valid and instr.
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;

   logic [ADDR_W-1:0]  read_reg1;
   logic [ADDR_W-1:0]  read_reg2;
   logic [DATA_W-1:0]  reg1;
   logic [DATA_W-1:0]  reg2;

   logic [ADDR_W-1:0]  write_reg;
   logic [DATA_W-1:0]  write_data;
   logic               wr_en;

   logic               done;
   logic               illegal;
   logic               zero;
   logic               busy;

   modport master (
      input  instr_valid, instr, reg1, reg2,
      output instr_ready, read_reg1, read_reg2, write_reg, write_data,
             wr_en, done, illegal, zero, busy
   );

   modport slave (
      output instr_valid, instr, reg1, reg2,
      input  instr_ready, read_reg1, read_reg2, write_reg, write_data,
             wr_en, done, illegal, zero, busy
   );

endinterface

// File: rtl/instr_sequencer_seq_mul16.sv
// Iterative shift-add multiplier returning the low W bits of a*b after W
// cycles; the first partial product is folded into the start cycle.
module seq_mul16 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_product
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_acc  <= i_b[0] ? i_a : '0;
            r_a    <= i_a << 1;
            r_b    <= i_b >> 1;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            if (r_b[0]) begin
               r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            // Step W-1 is the last multiplier bit; the product is final next cycle.
            if (r_cnt == CW'(W-1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_product = r_acc;

endmodule

// File: rtl/instr_sequencer.sv
// Control/execute stage for the 8x16 register file: accepts one instruction,
// reads its operands, executes it and issues a single registered write-back.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_sequencer_if.master bus,
   output state_t            o_dbg_state
);

   state_t              r_state;
   state_t              w_next;
   logic [INSTR_W-1:0]  r_instr;
   logic [DATA_W-1:0]   r_op1;
   logic [DATA_W-1:0]   r_op2;

   logic                r_wr_en;
   logic                r_done;
   logic                r_illegal;
   logic                r_zero;
   logic [ADDR_W-1:0]   r_write_reg;
   logic [DATA_W-1:0]   r_write_data;

   opcode_t             w_op;
   logic                w_legal;
   logic                w_no_exec;
   logic [DATA_W-1:0]   w_imm_sext;
   logic [DATA_W-1:0]   w_alu;

   logic                w_load_wb;
   logic                w_wb_wr;
   logic                w_wb_ill;
   logic [DATA_W-1:0]   w_wb_data;

   logic                w_mul_start;
   logic                w_mul_busy;
   logic                w_mul_done;
   logic [DATA_W-1:0]   w_mul_prod;

   assign w_op       = instr_op(r_instr);
   assign w_legal    = op_is_legal(w_op);
   assign w_no_exec  = (w_op == OP_NOP) || !w_legal;
   assign w_imm_sext = {{(DATA_W-IMM_W){r_instr[IMM_LSB+IMM_W-1]}},
                        r_instr[IMM_LSB +: IMM_W]};

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:  w_alu = r_op1 + r_op2;
         OP_SUB:  w_alu = r_op1 - r_op2;
         OP_AND:  w_alu = r_op1 & r_op2;
         OP_OR:   w_alu = r_op1 | r_op2;
         OP_XOR:  w_alu = r_op1 ^ r_op2;
         OP_SLL:  w_alu = r_op1 << r_op2[3:0];
         OP_SRL:  w_alu = r_op1 >> r_op2[3:0];
         OP_ADDI: w_alu = r_op1 + w_imm_sext;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_next      = r_state;
      w_load_wb   = 1'b0;
      w_wb_wr     = 1'b0;
      w_wb_ill    = 1'b0;
      w_wb_data   = '0;
      w_mul_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.instr_valid) begin
               w_next = S_READ;
            end
         end
         S_READ: begin
            // NOP and undefined opcodes have nothing to execute or write.
            if (w_no_exec) begin
               w_next    = S_WB;
               w_load_wb = 1'b1;
               w_wb_ill  = !w_legal;
            end else begin
               w_next      = S_EXEC;
               w_mul_start = (w_op == OP_MUL);
            end
         end
         S_EXEC: begin
            if (w_op == OP_MUL) begin
               if (w_mul_done) begin
                  w_next    = S_WB;
                  w_load_wb = 1'b1;
                  w_wb_wr   = 1'b1;
                  w_wb_data = w_mul_prod;
               end
            end else begin
               w_next    = S_WB;
               w_load_wb = 1'b1;
               w_wb_wr   = 1'b1;
               w_wb_data = w_alu;
            end
         end
         S_WB: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_op1   <= '0;
         r_op2   <= '0;
      end else begin
         if (r_state == S_IDLE && bus.instr_valid) begin
            r_instr <= bus.instr;
         end
         if (r_state == S_READ) begin
            r_op1 <= bus.reg1;
            r_op2 <= bus.reg2;
         end
      end
   end

   // Write-back outputs are registered so they hold steady across the whole
   // WB cycle and the register file's negedge commit lands mid-cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en      <= 1'b0;
         r_done       <= 1'b0;
         r_illegal    <= 1'b0;
         r_zero       <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else begin
         r_wr_en   <= w_load_wb & w_wb_wr;
         r_done    <= w_load_wb;
         r_illegal <= w_load_wb & w_wb_ill;
         r_zero    <= w_load_wb & w_wb_wr & (w_wb_data == '0);
         if (w_load_wb) begin
            r_write_reg  <= r_instr[RD_LSB +: ADDR_W];
            r_write_data <= w_wb_data;
         end
      end
   end

   seq_mul16 #(
      .W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_mul_start),
      .i_a       (bus.reg1),
      .i_b       (bus.reg2),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   assign bus.instr_ready = (r_state == S_IDLE);
   assign bus.busy        = (r_state != S_IDLE) || w_mul_busy;
   assign bus.read_reg1   = r_instr[RS_LSB +: ADDR_W];
   assign bus.read_reg2   = r_instr[RT_LSB +: ADDR_W];
   assign bus.write_reg   = r_write_reg;
   assign bus.write_data  = r_write_data;
   assign bus.wr_en       = r_wr_en;
   assign bus.done        = r_done;
   assign bus.illegal     = r_illegal;
   assign bus.zero        = r_zero;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer with a behavioural 8x16 register file and an
// arithmetic reference model of the instruction set.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int DW = 16;
   localparam int AW = 3;

   typedef struct packed {
      logic [7:0]  lat;
      logic [2:0]  after;
      logic        wr;
      logic        ill;
      logic        zero;
      logic [2:0]  wreg;
      logic [15:0] data;
   } obs_t;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   logic   rf_init = 1'b1;
   state_t dbg_state;

   instr_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   instr_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset / environment ----------------
   always #5 clk = ~clk;

   logic [DW-1:0] rf [8];
   always @(negedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf[i] <= DW'(i);
      end else if (bus.wr_en) begin
         rf[bus.write_reg] <= bus.write_data;
      end
   end
   assign bus.reg1 = rf[bus.read_reg1];
   assign bus.reg2 = rf[bus.read_reg2];

   int accept_cnt = 0;
   always @(posedge clk) begin
      if (rst_n && bus.instr_valid && bus.instr_ready) accept_cnt <= accept_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] mdl_rf [8];
   obs_t          exp_q [$];
   int            check_cnt = 0;
   int            err_cnt   = 0;

   function automatic logic [15:0] mk(input opcode_t op, input int rd, input int rs, input int rt);
      return {op, 3'(rd), 3'(rs), 3'(rt), 3'b000};
   endfunction

   // Expected outcome from the instruction-set definition alone.
   function automatic obs_t ref_model(input logic [15:0] ins);
      obs_t   e;
      int     op, imm;
      longint a, b, r;
      e       = '0;
      e.after = 3'b100;
      op  = int'(ins[15:12]);
      a   = longint'(mdl_rf[ins[8:6]]);
      b   = longint'(mdl_rf[ins[5:3]]);
      imm = int'(ins[5:0]);
      if (imm >= 32) imm = imm - 64;
      e.lat = (op == 0 || op > 9) ? 8'd2 : (op == 9) ? 8'd18 : 8'd3;
      e.ill = (op > 9);
      e.wr  = (op >= 1 && op <= 9);
      case (op)
         1: r = a + b;
         2: r = a - b;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = a << (b % 16);
         7: r = a >> (b % 16);
         8: r = a + longint'(imm);
         9: r = a * b;
         default: r = 0;
      endcase
      r = r & 64'hFFFF;
      if (e.wr) begin
         e.data = 16'(r);
         e.wreg = ins[11:9];
         e.zero = (r == 0);
      end
      return e;
   endfunction

   function automatic void mdl_commit(input obs_t e);
      if (e.wr) mdl_rf[e.wreg] = e.data;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_instr(input logic [15:0] ins, output obs_t o);
      int n = 0;
      o     = '0;
      o.lat = 8'hFF;
      @(negedge clk);
      while (!bus.instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            o.lat = 8'(c);
            o.wr  = bus.wr_en;
            o.ill = bus.illegal;
            if (bus.wr_en) begin
               o.zero = bus.zero;
               o.wreg = bus.write_reg;
               o.data = bus.write_data;
            end
            break;
         end
      end
      if (o.lat != 8'hFF) begin
         @(negedge clk);
         o.after = {bus.instr_ready, bus.done, bus.wr_en};
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] got [10];
      logic [15:0] want [10];
      string       nm [10];
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      rst_n   = 1'b0;
      rf_init = 1'b1;
      repeat (3) @(negedge clk);
      nm[0] = "reset_ready";   got[0] = 16'(bus.instr_ready); want[0] = 16'd1;
      nm[1] = "reset_busy";    got[1] = 16'(bus.busy);        want[1] = 16'd0;
      nm[2] = "reset_wr_en";   got[2] = 16'(bus.wr_en);       want[2] = 16'd0;
      nm[3] = "reset_done";    got[3] = 16'(bus.done);        want[3] = 16'd0;
      nm[4] = "reset_illegal"; got[4] = 16'(bus.illegal);     want[4] = 16'd0;
      nm[5] = "reset_zero";    got[5] = 16'(bus.zero);        want[5] = 16'd0;
      nm[6] = "reset_wreg";    got[6] = 16'(bus.write_reg);   want[6] = 16'd0;
      nm[7] = "reset_wdata";   got[7] = bus.write_data;       want[7] = 16'd0;
      nm[8] = "reset_rreg1";   got[8] = 16'(bus.read_reg1);   want[8] = 16'd0;
      nm[9] = "reset_state";   got[9] = 16'(dbg_state);       want[9] = 16'(S_IDLE);
      for (int i = 0; i < 10; i++) begin
         check_cnt++;
         if (got[i] !== want[i]) begin
            err_cnt++;
            $display("FAIL %s got %h want %h", nm[i], got[i], want[i]);
         end
      end
      rf_init = 1'b0;
      rst_n   = 1'b1;
      for (int i = 0; i < 8; i++) mdl_rf[i] = DW'(i);
   endtask

   task automatic test_alu_chain();
      logic [15:0] prog [3];
      obs_t        o, e;
      prog[0] = 16'h1650;
      prog[1] = mk(OP_SUB, 4, 2, 2);
      prog[2] = 16'h8B3F;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(ref_model(prog[i]));
         drive_instr(prog[i], o);
         e = exp_q.pop_front();
         mdl_commit(e);
         check_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL alu_chain[%0d] got %h want %h", i, o, e);
         end
      end
      check_cnt++;
      if (rf[3] !== 16'h0003 || rf[4] !== 16'h0000 || rf[5] !== 16'hFFFF) begin
         err_cnt++;
         $display("FAIL alu_chain_rf got r3=%h r4=%h r5=%h want 0003 0000 ffff", rf[3], rf[4], rf[5]);
      end
   endtask

   task automatic test_mul();
      logic [15:0] prog [2];
      obs_t        o, e;
      prog[0] = 16'h9DF8;
      prog[1] = mk(OP_MUL, 0, 5, 5);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(ref_model(prog[i]));
         drive_instr(prog[i], o);
         e = exp_q.pop_front();
         mdl_commit(e);
         check_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL mul[%0d] got %h want %h", i, o, e);
         end
      end
      check_cnt++;
      if (rf[6] !== 16'h0031 || rf[0] !== 16'h0001) begin
         err_cnt++;
         $display("FAIL mul_rf got r6=%h r0=%h want 0031 0001", rf[6], rf[0]);
      end
   endtask

   task automatic test_nop_illegal();
      logic [15:0] prog [4];
      obs_t        o, e;
      prog[0] = {4'hF, 12'($urandom)};
      prog[1] = {4'h0, 12'($urandom)};
      prog[2] = {4'hA, 12'($urandom)};
      prog[3] = {4'hF, 12'h000};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(ref_model(prog[i]));
         drive_instr(prog[i], o);
         e = exp_q.pop_front();
         check_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL nop_illegal[%0d] got %h want %h", i, o, e);
         end
      end
      for (int i = 0; i < 8; i++) begin
         check_cnt++;
         if (rf[i] !== mdl_rf[i]) begin
            err_cnt++;
            $display("FAIL nop_illegal_rf r%0d got %h want %h", i, rf[i], mdl_rf[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      obs_t o, e;
      // Abort a MUL in the middle of its iterations.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = mk(OP_MUL, 6, 5, 7);
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      check_cnt++;
      if (bus.busy !== 1'b1 || bus.instr_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL abort_mul_pre got busy=%b ready=%b want 1 0", bus.busy, bus.instr_ready);
      end
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if ({bus.instr_ready, bus.busy, bus.wr_en, bus.done} !== 4'b1000 || dbg_state !== S_IDLE) begin
         err_cnt++;
         $display("FAIL abort_mul_post got rdy/busy/wr/done=%b state=%0d want 1000 0",
                  {bus.instr_ready, bus.busy, bus.wr_en, bus.done}, dbg_state);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_cnt++;
      if (rf[6] !== mdl_rf[6]) begin
         err_cnt++;
         $display("FAIL abort_mul_rf got %h want %h", rf[6], mdl_rf[6]);
      end
      // Abort an ADD inside its write-back cycle, before the negedge commit.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = mk(OP_ADD, 1, 7, 7);
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_cnt++;
      if (bus.wr_en !== 1'b1 || bus.done !== 1'b1) begin
         err_cnt++;
         $display("FAIL abort_wb_pre got wr_en=%b done=%b want 1 1", bus.wr_en, bus.done);
      end
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if ({bus.instr_ready, bus.wr_en, bus.done} !== 3'b100) begin
         err_cnt++;
         $display("FAIL abort_wb_post got rdy/wr/done=%b want 100", {bus.instr_ready, bus.wr_en, bus.done});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_cnt++;
      if (rf[1] !== mdl_rf[1]) begin
         err_cnt++;
         $display("FAIL abort_wb_rf got %h want %h", rf[1], mdl_rf[1]);
      end
      // Same ADD issued again after recovery completes normally.
      exp_q.push_back(ref_model(mk(OP_ADD, 1, 7, 7)));
      drive_instr(mk(OP_ADD, 1, 7, 7), o);
      e = exp_q.pop_front();
      mdl_commit(e);
      check_cnt++;
      if (o !== e) begin
         err_cnt++;
         $display("FAIL abort_recover got %h want %h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      obs_t        ea, eb;
      logic [15:0] ia, ib;
      int          cnt0, first, second, n;
      logic [15:0] d1, d2;
      logic [2:0]  r1;
      ia = mk(OP_SLL, 1, 2, 3);
      ib = mk(OP_XOR, 4, 1, 3);
      ea = ref_model(ia);
      mdl_commit(ea);
      eb = ref_model(ib);
      mdl_commit(eb);
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      first = 0; second = 0; n = 0; d1 = '0; d2 = '0; r1 = '0;
      @(negedge clk);
      while (!bus.instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      cnt0 = accept_cnt;
      bus.instr_valid = 1'b1;
      bus.instr       = ia;
      @(posedge clk);
      #1 bus.instr = ib;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            first = c; d1 = bus.write_data; r1 = bus.write_reg;
            break;
         end
      end
      ea = exp_q.pop_front();
      check_cnt++;
      if (first != 3 || d1 !== 16'h0010 || d1 !== ea.data || r1 !== 3'd1 || accept_cnt != cnt0 + 1) begin
         err_cnt++;
         $display("FAIL b2b_first got lat=%0d data=%h reg=%0d acc=%0d want 3 0010 1 %0d",
                  first, d1, r1, accept_cnt - cnt0, 1);
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            second = c; d2 = bus.write_data;
            break;
         end
      end
      bus.instr_valid = 1'b0;
      eb = exp_q.pop_front();
      check_cnt++;
      if (second != 4 || d2 !== eb.data || accept_cnt != cnt0 + 2) begin
         err_cnt++;
         $display("FAIL b2b_second got gap=%0d data=%h acc=%0d want 4 %h 2",
                  second, d2, accept_cnt - cnt0, eb.data);
      end
      @(negedge clk);
      check_cnt++;
      if (bus.instr_ready !== 1'b1 || accept_cnt != cnt0 + 2) begin
         err_cnt++;
         $display("FAIL b2b_idle got ready=%b acc=%0d want 1 2", bus.instr_ready, accept_cnt - cnt0);
      end
   endtask

   task automatic test_random();
      obs_t        o, e;
      logic [15:0] ins;
      for (int i = 0; i < 40; i++) begin
         ins = {4'($urandom_range(0, 15)), 12'($urandom)};
         exp_q.push_back(ref_model(ins));
         drive_instr(ins, o);
         e = exp_q.pop_front();
         mdl_commit(e);
         check_cnt++;
         if (o !== e) begin
            err_cnt++;
            $display("FAIL random[%0d] instr=%h got %h want %h", i, ins, o, e);
         end
      end
      for (int i = 0; i < 8; i++) begin
         check_cnt++;
         if (rf[i] !== mdl_rf[i]) begin
            err_cnt++;
            $display("FAIL random_rf r%0d got %h want %h", i, rf[i], mdl_rf[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_alu_chain();
      test_mul();
      test_nop_illegal();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
